// File: rtl/audio_frame_pkg.sv
// audio_frame_pkg: shared write-FSM and bank-status types plus the frame-length helper
package audio_frame_pkg;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} w_state_t;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_status_t;
  function automatic int frame_len(input int addr_width);
    return 1 << (addr_width - 1);
  endfunction
  localparam int FRAME_LEN = frame_len(10);
endpackage

// File: rtl/audio_frame_pingpong_wr_if.sv
// audio_frame_pingpong_wr_if: sample stream in (in_*, flush), RAM port A out (ram_a_*), frame handoff (frm_*); slave = writer, master = producer/consumer side
interface audio_frame_pingpong_wr_if #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 18,
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [ADDR_WIDTH-1:0]   ram_a_addr;
  logic [DATA_WIDTH-1:0]   ram_a_wr_data;
  logic                    ram_a_wr_en;
  logic                    frm_valid;
  logic                    frm_bank;
  logic                    frm_done;
  modport master (
    output in_data, in_valid, flush, frm_done,
    input  in_ready, ram_a_addr, ram_a_wr_data, ram_a_wr_en, frm_valid, frm_bank
  );
  modport slave (
    input  in_data, in_valid, flush, frm_done,
    output in_ready, ram_a_addr, ram_a_wr_data, ram_a_wr_en, frm_valid, frm_bank
  );
endinterface

// File: rtl/pingpong_bank_tracker.sv
// pingpong_bank_tracker: per-bank status, in-order presentation (rd_bank, frm_valid), set_full/set_bank marks a bank FULL, release_bank frees the presented one
module pingpong_bank_tracker
  import audio_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_full,
  input  logic       set_bank,
  input  logic       release_bank,
  output logic [1:0] full,
  output logic       rd_bank,
  output logic       frm_valid
);
  bank_status_t st [2];
  bank_status_t st_n [2];
  logic rd_n;
  always_comb begin
    st_n = st;
    rd_n = rd_bank;
    if (set_full) st_n[set_bank] = FULL;
    if (release_bank && frm_valid) begin
      st_n[rd_bank] = EMPTY;
      rd_n = ~rd_bank;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st        <= '{EMPTY, EMPTY};
      rd_bank   <= 1'b0;
      frm_valid <= 1'b0;
    end else begin
      st        <= st_n;
      rd_bank   <= rd_n;
      frm_valid <= st_n[rd_n] == FULL;
    end
  assign full = {st[1] == FULL, st[0] == FULL};
endmodule

// File: rtl/audio_frame_pingpong_wr.sv
// audio_frame_pingpong_wr: ping-pong frame writer; clk/rst_n plus bus (slave): stream in -> RAM port A banks, full banks handed out on frm_valid/frm_bank, freed by frm_done
module audio_frame_pingpong_wr
  import audio_frame_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 18,
  parameter int SAMPLE_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  audio_frame_pingpong_wr_if.slave bus
);
  localparam int PW = ADDR_WIDTH - 1;
  w_state_t      state;
  logic [PW-1:0] wr_ptr;
  logic          wr_bank;
  logic          wr_last;
  logic          accept;
  logic          wrap;
  logic [1:0]    full;
  assign bus.in_ready = state == W_FILL && !bus.flush;
  assign accept = bus.in_valid && bus.in_ready;
  assign wrap = accept && wr_ptr == PW'(frame_len(ADDR_WIDTH) - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state             <= W_IDLE;
      wr_ptr            <= '0;
      wr_bank           <= 1'b0;
      wr_last           <= 1'b0;
      bus.ram_a_addr    <= '0;
      bus.ram_a_wr_data <= '0;
      bus.ram_a_wr_en   <= 1'b0;
    end else begin
      bus.ram_a_wr_en <= accept;
      wr_last         <= wrap;
      if (accept) begin
        bus.ram_a_addr    <= {wr_bank, wr_ptr};
        bus.ram_a_wr_data <= DATA_WIDTH'($signed(bus.in_data[SAMPLE_WIDTH-1:0]));
      end
      wr_ptr <= bus.flush ? '0 : wr_ptr + PW'(accept);
      if (wrap) wr_bank <= ~wr_bank;
      case (state)
        W_IDLE:  state <= W_FILL;
        W_FILL:  if (wrap && full[~wr_bank]) state <= W_WAIT;
        W_WAIT:  if (!full[wr_bank]) state <= W_FILL;
        default: state <= W_IDLE;
      endcase
    end
  // FULL is marked from wr_last (the cycle the last word is written), so frm_valid never precedes the RAM write
  pingpong_bank_tracker u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_full     (wr_last),
    .set_bank     (bus.ram_a_addr[ADDR_WIDTH-1]),
    .release_bank (bus.frm_done),
    .full         (full),
    .rd_bank      (bus.frm_bank),
    .frm_valid    (bus.frm_valid)
  );
endmodule

// File: doc/audio_frame_pingpong_wr.md
# audio_frame_pingpong_wr

Ping-pong frame writer sitting directly upstream of port A of the 1024×18 true dual-port audio RAM. It accepts a valid/ready stream of signed audio samples and writes them into one of two 512-word banks. When a bank is complete it hands that bank to the downstream consumer, which reads it through RAM port B. The block applies backpressure while both banks are held by the consumer.

## Interface
- `ADDR_WIDTH`, 10, RAM port-A address width; bank size is 2^(ADDR_WIDTH-1) words.
- `DATA_WIDTH`, 18, RAM port-A data width.
- `SAMPLE_WIDTH`, 16, input sample width; must be ≤ DATA_WIDTH.
- `clk` in 1: single clock; also drives RAM ports A and B.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in SAMPLE_WIDTH: signed sample.
- `in_valid` in 1: sample present.
- `in_ready` out 1: block can accept a sample.
- `flush` in 1: synchronous pulse; discards the partially filled bank.
- `ram_a_addr` out ADDR_WIDTH: connects to RAM `a_addr`.
- `ram_a_wr_data` out DATA_WIDTH: connects to RAM `a_wr_data`.
- `ram_a_wr_en` out 1: connects to RAM `a_wr_en`.
- `frm_valid` out 1: a full bank is available to the consumer.
- `frm_bank` out 1: index of that bank; the consumer reads base address `frm_bank << (ADDR_WIDTH-1)`.
- `frm_done` in 1: single-cycle pulse; the consumer releases the presented bank.

## Operation
- Bank status per bank: EMPTY, FILLING, or FULL.
- Write FSM states:
  - W_IDLE: reset state; goes to W_FILL unconditionally on the next clock.
  - W_FILL: `in_ready`=1 unless `flush` is high.
  - W_WAIT: the next bank is FULL; `in_ready`=0. Returns to W_FILL once that bank becomes EMPTY.
- Accept condition: `in_valid & in_ready`.
- On accept:
  - `ram_a_addr` = {wr_bank, wr_ptr}.
  - `ram_a_wr_data` = in_data sign-extended to DATA_WIDTH.
  - `ram_a_wr_en` = 1 for one cycle.
  - wr_ptr increments.
- wr_ptr wraps 511→0. On the wrap write:
  - the current bank is marked FULL;
  - wr_bank toggles;
  - FSM goes to W_WAIT if the new bank is FULL, otherwise stays in W_FILL.
- Consumer presentation:
  - rd_bank pointer, reset 0.
  - `frm_valid` = (bank[rd_bank] == FULL), registered.
  - `frm_bank` = rd_bank.
- `frm_done` while `frm_valid`=1: bank[rd_bank] becomes EMPTY and rd_bank toggles. Banks are therefore presented strictly in fill order.
- `frm_done` while `frm_valid`=0 is ignored.
- `flush`: wr_ptr is set to 0 and wr_bank stays the same. FULL banks are untouched. A sample offered in the same cycle is not accepted, because `in_ready` is low.
- Simultaneous events:
  - Wrap write and `frm_done` in the same cycle: both take effect.
  - W_WAIT and `frm_done` releasing the awaited bank: FSM re-enters W_FILL, and `in_ready`=1 on the following cycle.

## Timing
- Reset values: `in_ready`=0, `ram_a_wr_en`=0, `ram_a_addr`=0, `ram_a_wr_data`=0, `frm_valid`=0, `frm_bank`=0.
- Internal reset state: both banks EMPTY, wr_ptr=0, wr_bank=0.
- `in_ready` first rises in the second cycle after `rst_n` deasserts (one W_IDLE cycle).
- `in_ready` is combinational from FSM state and `flush`. All RAM-side outputs are registered.
- Write latency: sample accepted at edge N → `ram_a_wr_en` high during cycle N+1 → RAM write at edge N+1.
- `frm_valid` rises in cycle N+2 after the final (512th) sample is accepted at edge N. This is after the RAM write has completed, so port-B reads are safe immediately.
- `frm_done` at edge M → `frm_valid` falls (or re-presents the other bank) in cycle M+1.
- Reset asserted mid-frame: all state cleared asynchronously and partial data abandoned. RAM contents are not cleared.
- Throughput: one sample per clock while in W_FILL.

## Structure
- Package `audio_frame_pkg`:
  - write-FSM state enum {W_IDLE, W_FILL, W_WAIT};
  - bank-status enum {EMPTY, FILLING, FULL};
  - FRAME_LEN derived constant.
- Sub-module `pingpong_bank_tracker`:
  - holds both bank statuses and rd_bank;
  - inputs: set_full(bank), release;
  - outputs: full[1:0], rd_bank, frm_valid.
- The top level holds the write FSM, pointers and output registers.

## Test plan
- Reset release, stream 512 samples 0..511 back-to-back:
  - writes to addresses 0..511 with sign-extended data;
  - `frm_valid`=1 with `frm_bank`=0 two cycles after the last accept.
- Stream 1024 samples with no `frm_done`:
  - bank1 fills;
  - `in_ready`=0 after sample 1024; sample 1025 is held;
  - `frm_bank`=0.
- In the W_WAIT state above, pulse `frm_done`:
  - `frm_bank`=1 on the next cycle;
  - `in_ready`=1 one cycle later;
  - the next write goes to address 0.
- Write 100 samples, pulse `flush` concurrently with `in_valid`:
  - that sample is not accepted;
  - the next accepted sample is written to address 0 of the same bank.
- Input −1 (16'hFFFF): `ram_a_wr_data`=18'h3FFFF.
- Assert `rst_n` low during sample 300 of bank1 while bank0 is FULL: all outputs return to reset values immediately, and `frm_valid`=0 after release.
